// File: rtl/clahe_hist_pkg.sv
// clahe_hist_pkg
// Shared definitions for the CLAHE histogram bank memory:
//   - default widths and depth of a histogram bank
//   - encoding of the hardware clear-sweep state machine
//   - the all-ones count used when saturating increments are enabled
package clahe_hist_pkg;

    localparam int HIST_DATA_WIDTH = 16;
    localparam int HIST_ADDR_WIDTH = 8;
    localparam int HIST_DEPTH      = 256;
    localparam int HIST_NUM_BANKS  = 2;
    localparam int HIST_BANK_W     = 1;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

    localparam logic [HIST_DATA_WIDTH-1:0] HIST_SAT_MAX = {HIST_DATA_WIDTH{1'b1}};

endpackage

// File: rtl/clahe_true_dual_port_ram.sv
// clahe_true_dual_port_ram
// Single-clock true dual-port RAM with registered (1-cycle) reads on both
// ports. Reads are read-first: a read and a write to the same address at the
// same edge return the old contents. If both ports write the same address at
// the same edge, port B wins.
// Ports:
//   clk                 clock, rising edge
//   a_en/a_we/a_addr    port A enable, write enable, address
//   a_din/a_dout        port A write data / registered read data
//   b_en/b_we/b_addr    port B enable, write enable, address
//   b_din/b_dout        port B write data / registered read data
module clahe_true_dual_port_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    input  logic                  b_en,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic [DATA_WIDTH-1:0] b_dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Both ports share one process so the array has a single driver; port B
    // is written last so it takes priority on a same-address collision.
    always_ff @(posedge clk) begin
        if (a_en) begin
            if (a_we) begin
                mem[a_addr] <= a_din;
            end
            a_dout <= mem[a_addr];
        end
        if (b_en) begin
            if (b_we) begin
                mem[b_addr] <= b_din;
            end
            b_dout <= mem[b_addr];
        end
    end

endmodule

// File: rtl/clahe_hist_bank_ram.sv
// clahe_hist_bank_ram
// Multi-bank histogram memory for the CLAHE pipeline. Each bank is a true
// dual-port RAM; the top level adds a two-stage read-modify-write increment
// with forwarding, an external read port, and a clear sweep that zeroes one
// bank at a time.
// Configuration macro:
//   CLAHE_HIST_SAT_EN  defined: increments saturate at all-ones
//                      undefined: increments wrap from all-ones to zero
// Ports:
//   clk, rst                            clock, synchronous active-high reset
//   inc_valid/inc_ready/inc_bank/inc_addr  increment request handshake
//   rd_en/rd_bank/rd_addr               read request (1-cycle latency)
//   rd_data/rd_valid                    read result, data holds when not valid
//   rd_conflict                         read dropped by write-back collision
//   clr_start/clr_bank                  start clearing a bank
//   clr_busy/clr_done                   sweep in progress / completion pulse
module clahe_hist_bank_ram
    import clahe_hist_pkg::*;
#(
    parameter int DATA_WIDTH = HIST_DATA_WIDTH,
    parameter int ADDR_WIDTH = HIST_ADDR_WIDTH,
    parameter int DEPTH      = HIST_DEPTH,
    parameter int NUM_BANKS  = HIST_NUM_BANKS,
    parameter int BANK_W     = HIST_BANK_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_valid,
    output logic                  inc_ready,
    input  logic [BANK_W-1:0]     inc_bank,
    input  logic [ADDR_WIDTH-1:0] inc_addr,
    input  logic                  rd_en,
    input  logic [BANK_W-1:0]     rd_bank,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_conflict,
    input  logic                  clr_start,
    input  logic [BANK_W-1:0]     clr_bank,
    output logic                  clr_busy,
    output logic                  clr_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    clr_state_t            clr_state;
    logic [BANK_W-1:0]     clr_bank_q;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [BANK_W-1:0]     active_clr_bank;

    logic                  inc_fire;
    logic                  s1_valid;
    logic [BANK_W-1:0]     s1_bank;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [DATA_WIDTH-1:0] s1_operand;
    logic [DATA_WIDTH-1:0] s1_result;

    logic                  fwd_valid;
    logic [BANK_W-1:0]     fwd_bank;
    logic [ADDR_WIDTH-1:0] fwd_addr;
    logic [DATA_WIDTH-1:0] fwd_data;

    logic                  rd_collide;
    logic [BANK_W-1:0]     rd_bank_q;
    logic [DATA_WIDTH-1:0] rd_hold;

    logic [NUM_BANKS-1:0]  a_en;
    logic [NUM_BANKS-1:0]  a_we;
    logic [ADDR_WIDTH-1:0] a_addr [NUM_BANKS];
    logic [DATA_WIDTH-1:0] a_dout [NUM_BANKS];
    logic [NUM_BANKS-1:0]  b_en;
    logic [NUM_BANKS-1:0]  b_we;
    logic [ADDR_WIDTH-1:0] b_addr [NUM_BANKS];
    logic [DATA_WIDTH-1:0] b_dout [NUM_BANKS];

    // While idle a same-cycle clr_start already claims its bank, so the
    // blocked bank comes straight from the input; afterwards it is latched.
    assign active_clr_bank = (clr_state == CLR_IDLE) ? clr_bank : clr_bank_q;
    assign inc_ready       = !((clr_busy || clr_start) && (inc_bank == active_clr_bank));
    assign inc_fire        = inc_valid && inc_ready;

    // The RAM read issued in S0 cannot see a write-back landing on the same
    // edge, so that write-back is taken from the forward register instead.
    assign s1_operand = (fwd_valid && (fwd_bank == s1_bank) && (fwd_addr == s1_addr))
                        ? fwd_data : a_dout[s1_bank];

`ifdef CLAHE_HIST_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {DATA_WIDTH{1'b1}};
    assign s1_result = (s1_operand == SAT_MAX) ? s1_operand : s1_operand + 1'b1;
`else
    assign s1_result = s1_operand + 1'b1;
`endif

    // A read to the bank being written back loses port B to the write.
    assign rd_collide = rd_en && s1_valid && (rd_bank == s1_bank);

    assign rd_data = rd_valid ? b_dout[rd_bank_q] : rd_hold;

    // Port A carries either the clear sweep's zero write or the increment's
    // S0 read; inc_ready keeps the two apart on any one bank. Port B carries
    // either the S1 write-back or an external read.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            a_en[b]   = 1'b0;
            a_we[b]   = 1'b0;
            a_addr[b] = inc_addr;
            b_en[b]   = 1'b0;
            b_we[b]   = 1'b0;
            b_addr[b] = rd_addr;
            if ((clr_state == CLR_SWEEP) && (clr_bank_q == BANK_W'(b))) begin
                a_en[b]   = 1'b1;
                a_we[b]   = 1'b1;
                a_addr[b] = clr_addr;
            end else if (inc_fire && (inc_bank == BANK_W'(b))) begin
                a_en[b] = 1'b1;
            end
            if (s1_valid && (s1_bank == BANK_W'(b))) begin
                b_en[b]   = 1'b1;
                b_we[b]   = 1'b1;
                b_addr[b] = s1_addr;
            end else if (rd_en && (rd_bank == BANK_W'(b))) begin
                b_en[b] = 1'b1;
            end
        end
    end

    generate
        for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
            clahe_true_dual_port_ram #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .DEPTH      (DEPTH)
            ) u_ram (
                .clk    (clk),
                .a_en   (a_en[gb]),
                .a_we   (a_we[gb]),
                .a_addr (a_addr[gb]),
                .a_din  ({DATA_WIDTH{1'b0}}),
                .a_dout (a_dout[gb]),
                .b_en   (b_en[gb]),
                .b_we   (b_we[gb]),
                .b_addr (b_addr[gb]),
                .b_din  (s1_result),
                .b_dout (b_dout[gb])
            );
        end
    endgenerate

    // Increment pipeline, forward register and read-side status. The forward
    // entry is only valid the cycle after its write-back: older write-backs
    // are already visible in the RAM, and expiring it stops a stale count
    // from surviving a clear sweep of that bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_bank     <= '0;
            s1_addr     <= '0;
            fwd_valid   <= 1'b0;
            fwd_bank    <= '0;
            fwd_addr    <= '0;
            fwd_data    <= '0;
            rd_valid    <= 1'b0;
            rd_conflict <= 1'b0;
            rd_bank_q   <= '0;
            rd_hold     <= '0;
        end else begin
            s1_valid    <= inc_fire;
            s1_bank     <= inc_bank;
            s1_addr     <= inc_addr;
            fwd_valid   <= s1_valid;
            fwd_bank    <= s1_bank;
            fwd_addr    <= s1_addr;
            fwd_data    <= s1_result;
            rd_valid    <= rd_en && !rd_collide;
            rd_conflict <= rd_collide;
            rd_bank_q   <= rd_bank;
            rd_hold     <= rd_data;
        end
    end

    // Clear sweep: zero one address per cycle of the latched bank, then
    // spend one cycle in DONE to pulse clr_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_state  <= CLR_IDLE;
            clr_bank_q <= '0;
            clr_addr   <= '0;
            clr_busy   <= 1'b0;
            clr_done   <= 1'b0;
        end else begin
            case (clr_state)
                CLR_IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_start) begin
                        clr_state  <= CLR_SWEEP;
                        clr_bank_q <= clr_bank;
                        clr_addr   <= '0;
                        clr_busy   <= 1'b1;
                    end
                end
                CLR_SWEEP: begin
                    if (clr_addr == LAST_ADDR) begin
                        clr_state <= CLR_DONE;
                        clr_busy  <= 1'b0;
                        clr_done  <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                CLR_DONE: begin
                    clr_state <= CLR_IDLE;
                    clr_done  <= 1'b0;
                end
                default: begin
                    clr_state <= CLR_IDLE;
                    clr_busy  <= 1'b0;
                    clr_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clahe_hist_bank_ram.sv
// tb_clahe_hist_bank_ram
// Directed bench for clahe_hist_bank_ram: counting, forwarding, clear sweep
// alongside increments, read/write-back collision, overflow at all-ones and
// reset during a sweep. Honours CLAHE_HIST_SAT_EN for the overflow result.
module tb_clahe_hist_bank_ram;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int NB    = 2;
    localparam int BW    = 1;

    logic          clk;
    logic          rst;
    logic          inc_valid;
    logic          inc_ready;
    logic [BW-1:0] inc_bank;
    logic [AW-1:0] inc_addr;
    logic          rd_en;
    logic [BW-1:0] rd_bank;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_conflict;
    logic          clr_start;
    logic [BW-1:0] clr_bank;
    logic          clr_busy;
    logic          clr_done;

    int vecCount  = 0;
    int missCount = 0;

    clahe_hist_bank_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .NUM_BANKS  (NB),
        .BANK_W     (BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inc_valid   (inc_valid),
        .inc_ready   (inc_ready),
        .inc_bank    (inc_bank),
        .inc_addr    (inc_addr),
        .rd_en       (rd_en),
        .rd_bank     (rd_bank),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_conflict (rd_conflict),
        .clr_start   (clr_start),
        .clr_bank    (clr_bank),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of increment/read inputs, then step past the edge.
    task automatic applyStimulus(input int incV, input int incB, input int incA,
                                 input int rdE, input int rdB, input int rdA);
        inc_valid = 1'(incV);
        inc_bank  = BW'(incB);
        inc_addr  = AW'(incA);
        rd_en     = 1'(rdE);
        rd_bank   = BW'(rdB);
        rd_addr   = AW'(rdA);
        tick();
    endtask

    task automatic readCheck(input string tag, input int b, input int a, input int expData);
        applyStimulus(0, 0, 0, 1, b, a);
        checkOutput({tag, " valid"}, 32'(rd_valid), 32'd1);
        checkOutput(tag, 32'(rd_data), 32'(expData));
        rd_en = 1'b0;
    endtask

    task automatic runClear(input int b, input string tag);
        int n;
        inc_valid = 1'b0;
        rd_en     = 1'b0;
        clr_start = 1'b1;
        clr_bank  = BW'(b);
        tick();
        clr_start = 1'b0;
        checkOutput({tag, " busy"}, 32'(clr_busy), 32'd1);
        n = 1;
        while (!clr_done && n < 400) begin
            tick();
            n++;
        end
        checkOutput({tag, " done cycle"}, 32'(n), 32'(DEPTH + 1));
        checkOutput({tag, " busy at done"}, 32'(clr_busy), 32'd0);
        tick();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int incs;
        int orAcc;
        int validCnt;
        int doneSeen;
        logic [DW-1:0] expWrap;

        rst       = 1'b1;
        inc_valid = 1'b0;
        inc_bank  = '0;
        inc_addr  = '0;
        rd_en     = 1'b0;
        rd_bank   = '0;
        rd_addr   = '0;
        clr_start = 1'b0;
        clr_bank  = '0;
        repeat (3) tick();

        checkOutput("reset inc_ready",   32'(inc_ready),   32'd1);
        checkOutput("reset rd_data",     32'(rd_data),     32'd0);
        checkOutput("reset rd_valid",    32'(rd_valid),    32'd0);
        checkOutput("reset rd_conflict", 32'(rd_conflict), 32'd0);
        checkOutput("reset clr_busy",    32'(clr_busy),    32'd0);
        checkOutput("reset clr_done",    32'(clr_done),    32'd0);
        rst = 1'b0;
        tick();

        runClear(0, "clear bank0");
        runClear(1, "clear bank1");

        // Five back-to-back increments of one bin.
        repeat (5) applyStimulus(1, 0, 7, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        readCheck("b0 a7 after 5 inc", 0, 7, 5);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rd_valid idle", 32'(rd_valid), 32'd0);
        checkOutput("rd_data hold", 32'(rd_data), 32'd5);

        // Alternating bins exercise the forward path.
        applyStimulus(1, 0, 3, 0, 0, 0);
        applyStimulus(1, 0, 3, 0, 0, 0);
        applyStimulus(1, 0, 4, 0, 0, 0);
        applyStimulus(1, 0, 3, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        readCheck("b0 a3 fwd", 0, 3, 3);
        readCheck("b0 a4 fwd", 0, 4, 1);

        // Give bank 1 some non-zero bins before sweeping it.
        applyStimulus(1, 1, 5, 0, 0, 0);
        applyStimulus(1, 1, 5, 0, 0, 0);
        applyStimulus(1, 1, 255, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        readCheck("b1 a5 pre-clear", 1, 5, 2);
        readCheck("b1 a255 pre-clear", 1, 255, 1);

        // Sweep bank 1 while bank 0 keeps counting.
        rd_en     = 1'b0;
        clr_start = 1'b1;
        clr_bank  = 1'b1;
        inc_valid = 1'b1;
        inc_bank  = 1'b1;
        inc_addr  = 8'd5;
        #1;
        checkOutput("ready bank1 at clr_start", 32'(inc_ready), 32'd0);
        inc_bank = 1'b0;
        inc_addr = 8'd20;
        #1;
        checkOutput("ready bank0 at clr_start", 32'(inc_ready), 32'd1);
        tick();
        clr_start = 1'b0;
        checkOutput("sweep busy", 32'(clr_busy), 32'd1);
        incs = 1;
        n    = 1;
        while (!clr_done && n < 400) begin
            if (n == 100) begin
                inc_valid = 1'b1;
                inc_bank  = 1'b1;
                inc_addr  = 8'd9;
                #1;
                checkOutput("ready bank1 mid-sweep", 32'(inc_ready), 32'd0);
            end else if (n == 101) begin
                inc_valid = 1'b1;
                inc_bank  = 1'b0;
                inc_addr  = 8'd21;
                #1;
                checkOutput("ready bank0 mid-sweep", 32'(inc_ready), 32'd1);
            end else if (incs < 10) begin
                inc_valid = 1'b1;
                inc_bank  = 1'b0;
                inc_addr  = 8'd20;
                incs++;
            end else begin
                inc_valid = 1'b0;
            end
            tick();
            n++;
        end
        checkOutput("sweep done cycle", 32'(n), 32'(DEPTH + 1));
        checkOutput("sweep busy at done", 32'(clr_busy), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        orAcc    = 0;
        validCnt = 0;
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(0, 0, 0, 1, 1, a);
            orAcc    = orAcc | int'(rd_data);
            validCnt = validCnt + int'(rd_valid);
        end
        rd_en = 1'b0;
        checkOutput("bank1 all bins zero", 32'(orAcc), 32'd0);
        checkOutput("bank1 read valids", 32'(validCnt), 32'(DEPTH));

        readCheck("b0 a7 intact", 0, 7, 5);
        readCheck("b0 a3 intact", 0, 3, 3);
        readCheck("b0 a4 intact", 0, 4, 1);
        readCheck("b0 a20 during sweep", 0, 20, 10);
        readCheck("b0 a21 during sweep", 0, 21, 1);

        // Read colliding with the write-back of the same bank.
        applyStimulus(1, 0, 30, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 30);
        checkOutput("collide rd_conflict", 32'(rd_conflict), 32'd1);
        checkOutput("collide rd_valid", 32'(rd_valid), 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 30);
        checkOutput("retry rd_conflict", 32'(rd_conflict), 32'd0);
        checkOutput("retry rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("retry rd_data", 32'(rd_data), 32'd1);
        rd_en = 1'b0;

        // Overflow at all-ones.
        applyStimulus(0, 0, 0, 0, 0, 0);
        dut.g_bank[0].u_ram.mem[40] = 16'hFFFF;
`ifdef CLAHE_HIST_SAT_EN
        expWrap = 16'hFFFF;
`else
        expWrap = 16'h0000;
`endif
        applyStimulus(1, 0, 40, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        readCheck("b0 a40 overflow", 0, 40, int'(expWrap));

        // Reset in the middle of a sweep.
        applyStimulus(1, 1, 200, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        doneSeen  = 0;
        clr_start = 1'b1;
        clr_bank  = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (50) begin
            tick();
            doneSeen = doneSeen | int'(clr_done);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort busy drops", 32'(clr_busy), 32'd0);
        repeat (30) begin
            tick();
            doneSeen = doneSeen | int'(clr_done);
        end
        checkOutput("abort no clr_done", 32'(doneSeen), 32'd0);
        readCheck("b1 a200 after abort", 1, 200, 1);
        runClear(1, "clear after abort");
        readCheck("b1 a200 after reclear", 1, 200, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/clahe_hist_bank_ram.md
# clahe_hist_bank_ram

Multi-bank histogram memory with built-in read-modify-write increment, hazard forwarding, and a hardware clear sweep. It sits between the pixel binning stage and the CDF/clip stage of the CLAHE pipeline. One bank accumulates the current frame's tile histograms while another is read out, in ping-pong fashion. It replaces bare dual-port RAM plus external increment logic.

## Interface
- DATA_WIDTH, 16, bin count width
- ADDR_WIDTH, 8, bin address width
- DEPTH, 256, bins per bank
- NUM_BANKS, 2, independent banks
- BANK_W, 1, bank select width, equal to clog2(NUM_BANKS)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- inc_valid  in  1  increment request
- inc_ready  out  1  increment accepted when inc_valid && inc_ready
- inc_bank  in  BANK_W  target bank
- inc_addr  in  ADDR_WIDTH  target bin
- rd_en  in  1  read request
- rd_bank  in  BANK_W  read bank
- rd_addr  in  ADDR_WIDTH  read bin
- rd_data  out  DATA_WIDTH  read result
- rd_valid  out  1  rd_data valid
- rd_conflict  out  1  one-cycle pulse; read dropped due to a port collision
- clr_start  in  1  begin clearing clr_bank
- clr_bank  in  BANK_W  bank to clear
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse when the sweep completes

## Operation
- Per-bank port use:
  - Port A: increment read, or clear write (zero).
  - Port B: increment write-back, or external read.
- Increment pipeline:
  - S0 (accept cycle t): issue port A read of inc_addr.
  - S1 (t+1): operand = RAM dout, or forwarded data (see below); write operand+1 on port B of the same bank at the edge ending t+1.
- Forwarding: a register holds the last write-back (bank, addr, data, valid). If S1 bank/addr match it, S1 uses the held data instead of RAM dout. One entry is sufficient. Back-to-back increments to the same bin must count exactly.
- Reads: a port B read of rd_bank/rd_addr.
  - If S1 writes back to the same bank in the same cycle, the write-back wins.
  - In that case the read is dropped: rd_valid stays 0 and rd_conflict pulses.
- inc_ready = !((clr_busy || clr_start) && inc_bank == active clear bank). Increments to other banks proceed during a clear.
- Clear FSM states:
  - IDLE → SWEEP on clr_start. The bank is latched at this point.
  - SWEEP: writes zero to addresses 0..DEPTH-1, one per cycle, on port A.
  - SWEEP → DONE after address DEPTH-1.
  - DONE → IDLE after one cycle; clr_done=1 in DONE.
- clr_start while not IDLE is ignored.
- Arithmetic: DATA_WIDTH unsigned. Overflow behaviour is set by the macro below.
- RAM contents are not reset; software clears banks via the clear sweep.

## Timing
- Reset values: inc_ready=1, rd_data=0, rd_valid=0, rd_conflict=0, clr_busy=0, clr_done=0. Reset also clears the S1 valid, the forward register, and the FSM (to IDLE).
- Reset mid-sweep aborts the sweep. The bank is left partially cleared, and clr_done does not pulse.
- Read latency is 1: rd_en at t gives rd_data/rd_valid at t+1. rd_data holds its value when rd_valid=0.
- Increment visibility: a read issued at t+2 or later returns the value updated by an increment accepted at t.
- Clear timing:
  - clr_start at t: clr_busy is high over t+1..t+DEPTH, writing addr k at cycle t+1+k.
  - clr_done is high at t+DEPTH+1, with clr_busy low.
  - An increment accepted at t-1 writes back before the first clear write.
- Reads of a bank during its sweep are legal. The returned data is old or zero depending on the address.

## Configuration
- CLAHE_HIST_SAT_EN defined: the increment saturates at 2^DATA_WIDTH-1.
- Undefined: the increment wraps from all-ones to 0.

## Structure
- Package clahe_hist_pkg holds:
  - default widths/depth;
  - the clear FSM state encoding (IDLE, SWEEP, DONE);
  - the all-ones saturation constant.
- Sub-module: one clahe_true_dual_port_ram instance per bank, generated NUM_BANKS times. Port muxing, the increment pipeline, forwarding, and the FSM live in the top level.

## Test plan
- Clear bank 0. Apply 5 consecutive increments to bank 0 addr 7, then read: rd_data=5, rd_valid one cycle after rd_en.
- Alternate increments addr 3, 3, 4, 3 back-to-back: the forwarding path gives addr3=3 and addr4=1.
- Sweep bank 1 while incrementing bank 0:
  - clr_done pulses exactly DEPTH+1 cycles after clr_start;
  - all bank 1 bins read 0;
  - bank 0 counts are intact;
  - inc_ready is low only for bank 1 requests.
- Issue rd_en to the bank/addr being written back in that cycle: rd_conflict=1 and rd_valid=0. The next-cycle retry returns the new count.
- Preload a bin to 0xFFFF and increment: the result is 0xFFFF with CLAHE_HIST_SAT_EN, and 0x0000 without it.
- Assert rst in the middle of a sweep: clr_busy drops next cycle, clr_done never pulses, and a new clr_start completes normally.
